// File: rtl/data_memory_multi_port_arb_if.sv
// data_memory_multi_port_arb_if: per-port request/ready bus between the processor cores and the shared data memory.
interface data_memory_multi_port_arb_if #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16
);
    logic [NUM_PORTS-1:0]            req;
    logic [NUM_PORTS-1:0]            we;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_in;
    logic [NUM_PORTS-1:0]            ready;
    logic [NUM_PORTS-1:0]            rvalid;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_out;
    logic [NUM_PORTS-1:0]            addr_err;

    modport master (output req, we, addr, data_in, input ready, rvalid, data_out, addr_err);
    modport slave  (input req, we, addr, data_in, output ready, rvalid, data_out, addr_err);
endinterface

// File: rtl/data_memory_multi_port_arb.sv
// data_memory_multi_port_arb: multi-port data RAM with round-robin write-collision arbitration and registered reads.
// Optional build macro DMEM_WR_FORWARD_EN forwards a same-cycle committed write to a read of that address.
module data_memory_multi_port_arb #(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 1000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    data_memory_multi_port_arb_if.slave   bus,
    output logic [15:0]                   conflict_count
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int IW = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_A = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0]           ram [DEPTH];
    logic [ADDR_WIDTH-1:0]           a [NUM_PORTS];
    logic [DATA_WIDTH-1:0]           d [NUM_PORTS];
    logic [DATA_WIDTH-1:0]           rdata [NUM_PORTS];
    logic [IW-1:0]                   ai [NUM_PORTS];
    logic [NUM_PORTS-1:0]            inr, cand, rd, collide, win, stall, commit;
    logic [NUM_PORTS-1:0]            rvalid_q, addr_err_q;
    logic [NUM_PORTS*DATA_WIDTH-1:0] data_out_q;
    logic [PW-1:0]                   ptr, ptr_nxt;
    logic [ADDR_WIDTH-1:0]           min_a;
    logic                            found, have;
    int                              w, idx;

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            a[p]    = bus.addr[p*ADDR_WIDTH +: ADDR_WIDTH];
            d[p]    = bus.data_in[p*DATA_WIDTH +: DATA_WIDTH];
            ai[p]   = a[p][IW-1:0];
            inr[p]  = {1'b0, a[p]} < DEPTH_A;
            cand[p] = bus.req[p] & bus.we[p] & inr[p];
            rd[p]   = bus.req[p] & ~bus.we[p];
        end
    end

    // Each address group has exactly one winner: the first candidate at or after ptr.
    always_comb begin
        collide = '0;
        win     = '0;
        found   = 1'b0;
        w       = 0;
        idx     = 0;
        for (int p = 0; p < NUM_PORTS; p++)
            for (int q = 0; q < NUM_PORTS; q++)
                if (q != p && cand[p] && cand[q] && a[q] == a[p]) collide[p] = 1'b1;
        for (int p = 0; p < NUM_PORTS; p++) begin
            found = 1'b0;
            w     = 0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                idx = (int'(ptr) + k) % NUM_PORTS;
                if (!found && cand[idx] && a[idx] == a[p]) begin
                    found = 1'b1;
                    w     = idx;
                end
            end
            win[p] = w == p;
        end
        stall  = collide & ~win;
        commit = cand & ~stall;
    end

    always_comb begin
        have    = 1'b0;
        min_a   = '0;
        ptr_nxt = ptr;
        for (int p = 0; p < NUM_PORTS; p++)
            if (collide[p] && win[p] && (!have || a[p] < min_a)) begin
                have    = 1'b1;
                min_a   = a[p];
                ptr_nxt = PW'((p + 1) % NUM_PORTS);
            end
    end

    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            rdata[p] = inr[p] ? ram[ai[p]] : '0;
`ifdef DMEM_WR_FORWARD_EN
            for (int q = 0; q < NUM_PORTS; q++)
                if (inr[p] && commit[q] && a[q] == a[p]) rdata[p] = d[q];
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < NUM_PORTS; p++)
            if (rst_n && commit[p]) ram[ai[p]] <= d[p];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr            <= '0;
            rvalid_q       <= '0;
            addr_err_q     <= '0;
            data_out_q     <= '0;
            conflict_count <= '0;
        end else begin
            ptr        <= ptr_nxt;
            rvalid_q   <= rd;
            addr_err_q <= bus.req & ~inr;
            for (int p = 0; p < NUM_PORTS; p++)
                if (rd[p]) data_out_q[p*DATA_WIDTH +: DATA_WIDTH] <= rdata[p];
            if (|stall && conflict_count != 16'hFFFF) conflict_count <= conflict_count + 16'd1;
        end
    end

    assign bus.ready    = ~stall;
    assign bus.rvalid   = rvalid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_data_memory_multi_port_arb.sv
// tb_data_memory_multi_port_arb: directed checks of handshake, arbitration, read latency, range errors and reset.
module tb_data_memory_multi_port_arb;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] conflict_count;
    int          tests = 0;
    int          fails = 0;

    data_memory_multi_port_arb_if #(.NUM_PORTS(4), .DATA_WIDTH(16), .ADDR_WIDTH(16)) bus ();

    data_memory_multi_port_arb #(.NUM_PORTS(4), .DATA_WIDTH(16), .ADDR_WIDTH(16), .DEPTH(1000)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .conflict_count(conflict_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.req = '0;
        bus.we  = '0;
    endtask

    task automatic port(input int p, input logic w, input logic [15:0] ad, input logic [15:0] dt);
        bus.req[p]              = 1'b1;
        bus.we[p]               = w;
        bus.addr[p*16 +: 16]    = ad;
        bus.data_in[p*16 +: 16] = dt;
    endtask

    function automatic logic [15:0] dout(input int p);
        return bus.data_out[p*16 +: 16];
    endfunction

    logic [3:0] mask_t [4];
    logic [3:0] rdy_t [4];

    initial begin
        bus.addr    = '0;
        bus.data_in = '0;
        idle();
        #12;
        chk("rst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("rst_addr_err", 32'(bus.addr_err), 32'h0);
        chk("rst_conflict", 32'(conflict_count), 32'h0);
        chk("rst_data_out", bus.data_out[31:0], 32'h0);
        tick();
        rst_n = 1'b1;

        // single write then read on another port
        port(0, 1'b1, 16'd5, 16'h1234);
        #1 chk("wr5_ready", 32'(bus.ready), 32'hF);
        tick();
        idle();
        port(3, 1'b0, 16'd5, 16'h0);
        tick();
        idle();
        chk("rd5_rvalid", 32'(bus.rvalid), 32'h8);
        chk("rd5_data", 32'(dout(3)), 32'h1234);
        chk("rd5_conflict", 32'(conflict_count), 32'h0);
        tick();
        chk("rvalid_pulse", 32'(bus.rvalid), 32'h0);

        // four distinct addresses in one cycle
        for (int p = 0; p < 4; p++) port(p, 1'b1, 16'(10 + p), 16'(16'hA0 + p));
        #1 chk("distinct_ready", 32'(bus.ready), 32'hF);
        tick();
        for (int p = 0; p < 4; p++) port(p, 1'b0, 16'(10 + p), 16'h0);
        tick();
        idle();
        chk("distinct_rvalid", 32'(bus.rvalid), 32'hF);
        chk("distinct_data", {dout(1), dout(0)}, 32'h00A1_00A0);
        chk("distinct_data_hi", {dout(3), dout(2)}, 32'h00A3_00A2);

        // two-port collision with ptr=0: port 1 wins first
        port(1, 1'b1, 16'd20, 16'h1111);
        port(2, 1'b1, 16'd20, 16'h2222);
        #1 chk("col2_ready_c1", 32'(bus.ready), 32'hB);
        tick();
        bus.req[1] = 1'b0;
        #1 chk("col2_ready_c2", 32'(bus.ready), 32'hF);
        tick();
        idle();
        port(0, 1'b0, 16'd20, 16'h0);
        tick();
        idle();
        chk("col2_ram20", 32'(dout(0)), 32'h2222);
        chk("col2_conflict", 32'(conflict_count), 32'h1);

        // four-port collision starting at ptr=2: winners 2,3,0,1
        mask_t = '{4'b1111, 4'b1011, 4'b0011, 4'b0010};
        rdy_t  = '{4'b0100, 4'b1100, 4'b1101, 4'b1111};
        for (int p = 0; p < 4; p++) port(p, 1'b1, 16'd30, 16'(16'h30 + p));
        for (int i = 0; i < 4; i++) begin
            bus.req = mask_t[i];
            #1 chk($sformatf("col4_ready_c%0d", i), 32'(bus.ready), 32'(rdy_t[i]));
            tick();
        end
        idle();
        port(2, 1'b0, 16'd30, 16'h0);
        tick();
        idle();
        chk("col4_ram30", 32'(dout(2)), 32'h31);
        chk("col4_conflict", 32'(conflict_count), 32'h4);

        // same-cycle write/read of one address
        port(0, 1'b1, 16'd7, 16'h0001);
        tick();
        port(0, 1'b1, 16'd7, 16'hBEEF);
        port(1, 1'b0, 16'd7, 16'h0);
        tick();
        idle();
`ifdef DMEM_WR_FORWARD_EN
        chk("rw_same_addr", 32'(dout(1)), 32'hBEEF);
`else
        chk("rw_same_addr", 32'(dout(1)), 32'h0001);
`endif
        port(1, 1'b0, 16'd7, 16'h0);
        tick();
        idle();
        chk("rw_after", 32'(dout(1)), 32'hBEEF);

        // out-of-range read and write
        port(2, 1'b0, 16'd1000, 16'h0);
        port(3, 1'b1, 16'd1023, 16'h5555);
        #1 chk("oor_ready", 32'(bus.ready), 32'hF);
        tick();
        idle();
        chk("oor_rvalid", 32'(bus.rvalid), 32'h4);
        chk("oor_rdata", 32'(dout(2)), 32'h0);
        chk("oor_addr_err", 32'(bus.addr_err), 32'hC);
        chk("oor_hold_dout3", 32'(dout(3)), 32'h00A3);
        chk("oor_conflict", 32'(conflict_count), 32'h4);
        tick();
        chk("oor_err_pulse", 32'(bus.addr_err), 32'h0);

        // asynchronous reset during a read
        port(0, 1'b0, 16'd5, 16'h0);
        tick();
        chk("prerst_rvalid", 32'(bus.rvalid), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("midrst_rvalid", 32'(bus.rvalid), 32'h0);
        chk("midrst_conflict", 32'(conflict_count), 32'h0);
        idle();
        port(0, 1'b1, 16'd5, 16'hFFFF);
        tick();
        chk("inrst_rvalid", 32'(bus.rvalid), 32'h0);
        idle();
        rst_n = 1'b1;
        port(1, 1'b0, 16'd5, 16'h0);
        tick();
        idle();
        chk("inrst_nowrite", 32'(dout(1)), 32'h1234);

        // ptr back at 0 after reset: port 0 beats port 3
        port(0, 1'b1, 16'd40, 16'h4000);
        port(3, 1'b1, 16'd40, 16'h4003);
        #1 chk("postrst_ptr", 32'(bus.ready), 32'h7);
        tick();
        idle();
        chk("postrst_conflict", 32'(conflict_count), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/data_memory_multi_port_arb.md
Name: data_memory_multi_port_arb

Overview:
- Parametrised successor to the fixed 4-port, 16-bit data memory used by the matrix-multiply cores.
- Adds a per-port request/ready handshake, round-robin arbitration of same-address write collisions, and registered reads with a valid strobe.
- Also flags out-of-range addresses and keeps a saturating conflict counter.
- Sits between the NUM_PORTS processor cores and the shared data RAM.

Parameters:
NUM_PORTS, 4, number of independent access ports (2..8)
DATA_WIDTH, 16, word width in bits
ADDR_WIDTH, 16, address width in bits
DEPTH, 1000, number of words; valid addresses are 0..DEPTH-1

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  NUM_PORTS  per-port access request
we  input  NUM_PORTS  per-port write enable; qualified by req
addr  input  NUM_PORTS*ADDR_WIDTH  packed addresses, port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
data_in  input  NUM_PORTS*DATA_WIDTH  packed write data, same packing
ready  output  NUM_PORTS  combinational; the request is accepted this cycle when req&ready
rvalid  output  NUM_PORTS  one-cycle pulse: read data valid
data_out  output  NUM_PORTS*DATA_WIDTH  registered read data, held until the next accepted read
addr_err  output  NUM_PORTS  one-cycle pulse one cycle after an accepted out-of-range access
conflict_count  output  16  saturating count of cycles with at least one stalled port

Behaviour:
- Reset (rst_n low, asynchronous):
  - rvalid, data_out, addr_err, conflict_count and the priority pointer ptr clear to 0.
  - RAM contents are not cleared.
  - Requests presented while reset is asserted are ignored; no writes commit.
  - A read accepted in the cycle reset asserts produces no rvalid.
- Write candidate: port p with req&we and addr < DEPTH.
- Collision: two or more candidates share one address in a cycle.
  - Winner = first colliding index found scanning upward from ptr, modulo NUM_PORTS.
  - ready is low for the losers; ready is high for every other port.
  - Losers must hold req, we, addr and data_in until ready rises.
- Reads and out-of-range accesses are never stalled.
- Writes: every accepted in-range write commits on the rising edge. Distinct addresses all commit in the same cycle.
- ptr update: after any cycle with a collision, ptr <= (winner of the lowest colliding address group) + 1 mod NUM_PORTS. Otherwise ptr holds.
  - This guarantees a stalled port wins within NUM_PORTS-1 collision cycles.
- Reads:
  - Latency is 1 cycle: rvalid[p]=1 and data_out slice = ram[addr] in the cycle after acceptance.
  - Back-to-back reads every cycle are supported.
- Read of an address being written by another port in the same cycle returns the old data (see optional feature).
- Out-of-range access (addr >= DEPTH):
  - Accepted immediately.
  - A write is dropped.
  - A read returns 0 with rvalid.
  - addr_err[p] pulses one cycle later.
- conflict_count: +1 in each cycle where any ready bit is low; holds at 16'hFFFF once saturated.
- No combinational path from data_in to data_out.

Optional Feature:
- Macro: DMEM_WR_FORWARD_EN.
- Defined: a read accepted in the same cycle as a committed write to the same address returns the newly written data (winner's data_in).
- Undefined: such a read returns the pre-write contents.
- Arbitration, latency and all other behaviour are identical in both builds.

Test Plan:
- Reset, then write 16'h1234 to addr 5 on port 0; next cycle read addr 5 on port 3 -> one cycle later rvalid[3]=1, data_out[3]=16'h1234, conflict_count=0.
- Ports 0..3 write distinct addrs 10..13 with 16'hA0..16'hA3 in one cycle -> all ready=1; subsequent reads return 16'hA0..16'hA3.
- Ports 1 and 2 write addr 20 (16'h1111 / 16'h2222) with ptr=0, held until accepted:
  - Cycle 1: ready[2]=0 and port 1 commits; ptr becomes 2.
  - Cycle 2: port 2 commits; final ram[20]=16'h2222; conflict_count=1.
  - Repeat with all 4 ports colliding continuously -> each port wins exactly once within 4 cycles.
- Port 0 writes 16'hBEEF to addr 7 (old value 16'h0001) while port 1 reads addr 7 -> data_out[1]=16'h0001 without DMEM_WR_FORWARD_EN, 16'hBEEF with it.
- Port 2 reads addr 1000 and port 3 writes addr 1023:
  - Port 2: rvalid[2]=1, data_out[2]=0, addr_err[2]=1 one cycle later.
  - Port 3: addr_err[3]=1 one cycle later; no RAM change.
  - Drive rst_n low mid-read -> rvalid and conflict_count immediately 0.
